id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding. Sits directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle, supporting stall and flush.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's in1/in2/ALUCtrl/Sign and passes memory/writeback control onward to EX/MEM.

Parameters:
- DATA_W, 32, operand/result width
- RADDR_W, 5, register address width
- CTRL_W, 5, ALU control code width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold ID/EX contents (load-use or downstream stall)
- flush  in  1  load a bubble (branch/jump redirect, load-use bubble)
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr  in  RADDR_W  source register numbers
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm32  in  DATA_W  extended immediate (lui already shifted)
- id_shamt  in  5  instruction shamt field
- id_alu_src1  in  1  0: rs, 1: shamt
- id_alu_src2  in  1  0: rt, 1: imm32
- id_alu_ctrl  in  CTRL_W  ALU operation code
- id_sign  in  1  signed compare select
- id_dst  in  RADDR_W  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  downstream control
- id_mem_to_reg  in  2  writeback select
- id_pc_plus4  in  DATA_W  link address
- exmem_reg_write  in  1  EX/MEM will write a register
- exmem_dst  in  RADDR_W  EX/MEM destination register
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB will write a register
- memwb_dst  in  RADDR_W  MEM/WB destination register
- memwb_result  in  DATA_W  MEM/WB writeback value
- alu_in1, alu_in2  out  DATA_W  ALU operands (combinational from registers plus forwarding)
- alu_ctrl  out  CTRL_W  registered operation code
- alu_sign  out  1  registered sign select
- ex_store_data  out  DATA_W  forwarded rt value for sw
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_mem_to_reg  out  2  registered writeback select
- ex_dst, ex_rs_addr, ex_rt_addr  out  RADDR_W  registered addresses (hazard unit taps ex_dst/ex_mem_read)
- ex_pc_plus4  out  DATA_W  registered link address

Behaviour:
- Reset (reset=0, asynchronous): every register is cleared to 0 and ex_valid=0, so every output is 0. Release is synchronous to the next edge.
- Per edge, priority is flush > stall > load:
  - flush: bubble. All fields cleared to 0, including valid/reg_write/mem_read/mem_write, and alu_ctrl = NOP (10).
  - stall with no flush: all registers hold.
  - Otherwise capture all id_* fields. If id_valid=0, capture as a bubble.
- Latency: one cycle from ID inputs to registered outputs. The forwarding path is combinational within the EX cycle.
- Forward select, per source (rs, rt), independently:
  - If addr==0: value is 0, never forwarded.
  - Else if exmem_reg_write and exmem_dst==addr: exmem_result.
  - Else if memwb_reg_write and memwb_dst==addr: memwb_result.
  - Else the registered register-file data.
  - EX/MEM beats MEM/WB when both match.
- alu_in1:
  - src1=1: zero-extended shamt.
  - src1=0 and alu_ctrl in {6,7,8} (variable shifts): zero-extended forwarded rs[4:0].
  - Else forwarded rs.
- alu_in2: src2=1 gives imm32; else forwarded rt.
- ex_store_data is always forwarded rt, regardless of src2.
- Forwarding mux inputs update every cycle even while stalled. Held instructions therefore see fresh forwarded values; captured register data is not re-sampled.
- Bubbles never forward: downstream stages gate reg_write with valid.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SRA=8, SLT=9, NOP=10
  - forward-select enum: FWD_RF, FWD_EXMEM, FWD_MEMWB
  - mem_to_reg encodings
- One sub-module, fwd_mux: address compare plus 3-way select, instantiated for rs and rt.

Test Plan:
- Reset asserted mid-capture with id_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first edge captures normally.
- add $3,$1,$2 in EX with exmem_reg_write=1, exmem_dst=1, exmem_result=0x10; memwb_dst=1, memwb_result=0x20; rt data 5 -> alu_in1=0x10, alu_in2=5.
- Source $0 with exmem_dst=0, exmem_reg_write=1, exmem_result=0xFFFF -> operand 0.
- sll with shamt=4, src1=1 -> alu_in1=4. sllv with forwarded rs=0xFFFFFF23 -> alu_in1=0x3.
- stall and flush both high on the same edge -> bubble: ex_valid=0, alu_ctrl=10. Stall alone for 3 cycles -> outputs held, and a forwarded value arriving on cycle 2 appears on alu_in2.
- sw with src2=1, imm32=8, rt forwarded from MEM/WB value 0xDEAD -> alu_in2=8, ex_store_data=0xDEAD.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, forwarding selects and
// writeback source encodings.
package pipe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_NOR = 5'd5,
        ALU_SLL = 5'd6,
        ALU_SRL = 5'd7,
        ALU_SRA = 5'd8,
        ALU_SLT = 5'd9,
        ALU_NOP = 5'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'd0,
        MTR_MEM  = 2'd1,
        MTR_LINK = 2'd2
    } mem_to_reg_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM wins over MEM/WB,
// and register $0 always reads as zero.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_dst,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_dst,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (addr != '0) begin
            if (exmem_reg_write && (exmem_dst == addr)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_dst == addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        data = '0;
        case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_result;
            default:   data = (addr == '0) ? '0 : rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding feeding the ALU.
// Forwarding is evaluated every cycle, so a stalled instruction sees fresh results.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CTRL_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm32,
    input  logic [4:0]         id_shamt,
    input  logic               id_alu_src1,
    input  logic               id_alu_src2,
    input  logic [CTRL_W-1:0]  id_alu_ctrl,
    input  logic               id_sign,
    input  logic [RADDR_W-1:0] id_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [1:0]         id_mem_to_reg,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_dst,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_dst,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               alu_sign,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [1:0]         ex_mem_to_reg,
    output logic [RADDR_W-1:0] ex_dst,
    output logic [RADDR_W-1:0] ex_rs_addr,
    output logic [RADDR_W-1:0] ex_rt_addr,
    output logic [DATA_W-1:0]  ex_pc_plus4
);

    logic               valid_q;
    logic [RADDR_W-1:0] rs_addr_q;
    logic [RADDR_W-1:0] rt_addr_q;
    logic [DATA_W-1:0]  rs_data_q;
    logic [DATA_W-1:0]  rt_data_q;
    logic [DATA_W-1:0]  imm32_q;
    logic [4:0]         shamt_q;
    logic               alu_src1_q;
    logic               alu_src2_q;
    logic [CTRL_W-1:0]  alu_ctrl_q;
    logic               sign_q;
    logic [RADDR_W-1:0] dst_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [1:0]         mem_to_reg_q;
    logic [DATA_W-1:0]  pc_plus4_q;

    // An invalid ID slot is loaded exactly like a flush, but a stall still holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm32_q      <= '0;
            shamt_q      <= '0;
            alu_src1_q   <= 1'b0;
            alu_src2_q   <= 1'b0;
            alu_ctrl_q   <= '0;
            sign_q       <= 1'b0;
            dst_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= '0;
            pc_plus4_q   <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            valid_q      <= 1'b0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm32_q      <= '0;
            shamt_q      <= '0;
            alu_src1_q   <= 1'b0;
            alu_src2_q   <= 1'b0;
            alu_ctrl_q   <= CTRL_W'(ALU_NOP);
            sign_q       <= 1'b0;
            dst_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= '0;
            pc_plus4_q   <= '0;
        end else if (!stall) begin
            valid_q      <= 1'b1;
            rs_addr_q    <= id_rs_addr;
            rt_addr_q    <= id_rt_addr;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm32_q      <= id_imm32;
            shamt_q      <= id_shamt;
            alu_src1_q   <= id_alu_src1;
            alu_src2_q   <= id_alu_src2;
            alu_ctrl_q   <= id_alu_ctrl;
            sign_q       <= id_sign;
            dst_q        <= id_dst;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
            pc_plus4_q   <= id_pc_plus4;
        end
    end

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
        .addr            (rs_addr_q),
        .rf_data         (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_result    (memwb_result),
        .data            (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
        .addr            (rt_addr_q),
        .rf_data         (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_result    (memwb_result),
        .data            (rt_fwd)
    );

    logic var_shift;
    assign var_shift = (alu_ctrl_q == CTRL_W'(ALU_SLL)) ||
                       (alu_ctrl_q == CTRL_W'(ALU_SRL)) ||
                       (alu_ctrl_q == CTRL_W'(ALU_SRA));

    // Variable shifts take only the low five bits of rs as the shift amount.
    always_comb begin
        alu_in1 = rs_fwd;
        if (alu_src1_q) begin
            alu_in1 = {{(DATA_W-5){1'b0}}, shamt_q};
        end else if (var_shift) begin
            alu_in1 = {{(DATA_W-5){1'b0}}, rs_fwd[4:0]};
        end
    end

    always_comb begin
        alu_in2 = alu_src2_q ? imm32_q : rt_fwd;
    end

    assign ex_store_data = rt_fwd;
    assign alu_ctrl      = alu_ctrl_q;
    assign alu_sign      = sign_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_dst        = dst_q;
    assign ex_rs_addr    = rs_addr_q;
    assign ex_rt_addr    = rt_addr_q;
    assign ex_pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding priority,
// $0 handling, shift operand selection, stall/flush and store data.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm32;
    logic [4:0]  id_shamt;
    logic        id_alu_src1;
    logic        id_alu_src2;
    logic [4:0]  id_alu_ctrl;
    logic        id_sign;
    logic [4:0]  id_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic [1:0]  id_mem_to_reg;
    logic [31:0] id_pc_plus4;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_result;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_ctrl;
    logic        alu_sign;
    logic [31:0] ex_store_data;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_to_reg;
    logic [4:0]  ex_dst;
    logic [4:0]  ex_rs_addr;
    logic [4:0]  ex_rt_addr;
    logic [31:0] ex_pc_plus4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    id_ex_stage #(.DATA_W(32), .RADDR_W(5), .CTRL_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm32        (id_imm32),
        .id_shamt        (id_shamt),
        .id_alu_src1     (id_alu_src1),
        .id_alu_src2     (id_alu_src2),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_sign         (id_sign),
        .id_dst          (id_dst),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_pc_plus4     (id_pc_plus4),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_result    (memwb_result),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .alu_ctrl        (alu_ctrl),
        .alu_sign        (alu_sign),
        .ex_store_data   (ex_store_data),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_dst          (ex_dst),
        .ex_rs_addr      (ex_rs_addr),
        .ex_rt_addr      (ex_rt_addr),
        .ex_pc_plus4     (ex_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm32 = 0; id_shamt = 0; id_alu_src1 = 0; id_alu_src2 = 0;
        id_alu_ctrl = 0; id_sign = 0; id_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_pc_plus4 = 0;
        exmem_reg_write = 0; exmem_dst = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dst = 0; memwb_result = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        #3;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ex_valid); end
        checks++; if (alu_ctrl !== 5'd0) begin errors++; $display("FAIL reset_ctrl: got %0d expected 0", alu_ctrl); end
        #4 reset = 1;
        id_valid = 1; id_rs_addr = 1; id_rs_data = 32'h55; id_alu_ctrl = 5'd1;
        id_dst = 9; id_reg_write = 1; id_sign = 1; id_pc_plus4 = 32'h100;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_dst !== 5'd9) begin errors++; $display("FAIL pre_reset_capture: valid=%0b dst=%0d expected 1/9", ex_valid, ex_dst); end
        #2 reset = 0;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: valid=%0b rw=%0b expected 0/0", ex_valid, ex_reg_write); end
        checks++; if (alu_ctrl !== 5'd0 || alu_sign !== 1'b0 || ex_dst !== 5'd0) begin errors++; $display("FAIL async_reset_fields: ctrl=%0d sign=%0b dst=%0d expected 0/0/0", alu_ctrl, alu_sign, ex_dst); end
        checks++; if (alu_in1 !== 32'h0 || ex_pc_plus4 !== 32'h0 || ex_rs_addr !== 5'd0) begin errors++; $display("FAIL async_reset_data: in1=%h pc=%h rs=%0d expected 0", alu_in1, ex_pc_plus4, ex_rs_addr); end
        #1 reset = 1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc_plus4 !== 32'h100 || alu_in1 !== 32'h55) begin errors++; $display("FAIL post_reset_capture: valid=%0b pc=%h in1=%h expected 1/100/55", ex_valid, ex_pc_plus4, alu_in1); end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rs_data = 32'h111; id_rt_data = 32'h5;
        id_alu_ctrl = 5'd0; id_dst = 3; id_reg_write = 1;
        tick();
        exmem_reg_write = 1; exmem_dst = 1; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_dst = 1; memwb_result = 32'h20;
        #1;
        checks++; if (alu_in1 !== 32'h10) begin errors++; $display("FAIL fwd_exmem_wins: got %h expected 10", alu_in1); end
        checks++; if (alu_in2 !== 32'h5) begin errors++; $display("FAIL fwd_rt_rf: got %h expected 5", alu_in2); end
        exmem_reg_write = 0;
        #1;
        checks++; if (alu_in1 !== 32'h20) begin errors++; $display("FAIL fwd_memwb: got %h expected 20", alu_in1); end
        memwb_dst = 2;
        #1;
        checks++; if (alu_in1 !== 32'h111 || alu_in2 !== 32'h20) begin errors++; $display("FAIL fwd_rt_memwb: in1=%h in2=%h expected 111/20", alu_in1, alu_in2); end
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        id_valid = 1; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 32'h77; id_rt_data = 32'h88;
        tick();
        exmem_reg_write = 1; exmem_dst = 0; exmem_result = 32'hFFFF;
        memwb_reg_write = 1; memwb_dst = 0; memwb_result = 32'h1234;
        #1;
        checks++; if (alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL zero_reg: in1=%h in2=%h expected 0/0", alu_in1, alu_in2); end
    endtask

    task automatic test_shifts();
        clear_inputs();
        id_valid = 1; id_alu_src1 = 1; id_shamt = 4; id_rs_addr = 5; id_rs_data = 32'h99; id_alu_ctrl = 5'd6;
        tick();
        checks++; if (alu_in1 !== 32'h4) begin errors++; $display("FAIL sll_shamt: got %h expected 4", alu_in1); end
        id_alu_src1 = 0; id_shamt = 0;
        tick();
        exmem_reg_write = 1; exmem_dst = 5; exmem_result = 32'hFFFFFF23;
        #1;
        checks++; if (alu_in1 !== 32'h3) begin errors++; $display("FAIL sllv_fwd: got %h expected 3", alu_in1); end
        id_alu_ctrl = 5'd0;
        tick();
        checks++; if (alu_in1 !== 32'hFFFFFF23) begin errors++; $display("FAIL add_full_rs: got %h expected ffffff23", alu_in1); end
        exmem_reg_write = 0; id_alu_ctrl = 5'd8; id_rs_data = 32'h45;
        tick();
        checks++; if (alu_in1 !== 32'h5) begin errors++; $display("FAIL srav_rf: got %h expected 5", alu_in1); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1; id_alu_ctrl = 5'd2; id_dst = 7; id_reg_write = 1;
        tick();
        stall = 1; flush = 1;
        tick();
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 5'd10) begin errors++; $display("FAIL stall_flush_bubble: valid=%0b ctrl=%0d expected 0/10", ex_valid, alu_ctrl); end
        checks++; if (ex_reg_write !== 1'b0 || ex_dst !== 5'd0) begin errors++; $display("FAIL flush_ctl: rw=%0b dst=%0d expected 0/0", ex_reg_write, ex_dst); end
        stall = 0; flush = 0;
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rt_data = 32'h9; id_alu_ctrl = 5'd1; id_dst = 4;
        tick();
        stall = 1; id_alu_ctrl = 5'd3; id_rt_data = 32'h99; id_dst = 12;
        tick();
        checks++; if (alu_ctrl !== 5'd1 || alu_in2 !== 32'h9) begin errors++; $display("FAIL stall_c1: ctrl=%0d in2=%h expected 1/9", alu_ctrl, alu_in2); end
        tick();
        memwb_reg_write = 1; memwb_dst = 2; memwb_result = 32'hABC;
        #1;
        checks++; if (alu_in2 !== 32'hABC || ex_dst !== 5'd4) begin errors++; $display("FAIL stall_c2_fwd: in2=%h dst=%0d expected abc/4", alu_in2, ex_dst); end
        tick();
        checks++; if (ex_valid !== 1'b1 || alu_ctrl !== 5'd1 || alu_in2 !== 32'hABC) begin errors++; $display("FAIL stall_c3: valid=%0b ctrl=%0d in2=%h expected 1/1/abc", ex_valid, alu_ctrl, alu_in2); end
        stall = 0; memwb_reg_write = 0;
        tick();
        checks++; if (alu_ctrl !== 5'd3 || alu_in2 !== 32'h99 || ex_dst !== 5'd12) begin errors++; $display("FAIL stall_release: ctrl=%0d in2=%h dst=%0d expected 3/99/12", alu_ctrl, alu_in2, ex_dst); end
        id_valid = 0;
        tick();
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 5'd10 || ex_dst !== 5'd0) begin errors++; $display("FAIL invalid_bubble: valid=%0b ctrl=%0d dst=%0d expected 0/10/0", ex_valid, alu_ctrl, ex_dst); end
    endtask

    task automatic test_store();
        clear_inputs();
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 7; id_rs_data = 32'h1000; id_rt_data = 32'h1;
        id_imm32 = 32'h8; id_alu_src2 = 1; id_mem_write = 1; id_alu_ctrl = 5'd0;
        tick();
        memwb_reg_write = 1; memwb_dst = 7; memwb_result = 32'hDEAD;
        #1;
        checks++; if (alu_in2 !== 32'h8) begin errors++; $display("FAIL sw_imm: got %h expected 8", alu_in2); end
        checks++; if (ex_store_data !== 32'hDEAD) begin errors++; $display("FAIL sw_store_data: got %h expected dead", ex_store_data); end
        checks++; if (ex_mem_write !== 1'b1 || ex_rt_addr !== 5'd7 || alu_in1 !== 32'h1000) begin errors++; $display("FAIL sw_ctl: mw=%0b rt=%0d in1=%h expected 1/7/1000", ex_mem_write, ex_rt_addr, alu_in1); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        id_valid = 1; id_rs_addr = 3; id_rt_addr = 4; id_dst = 8; id_mem_read = 1; id_mem_to_reg = 2'd1;
        id_reg_write = 1; id_pc_plus4 = 32'h200; id_sign = 1; id_alu_ctrl = 5'd9;
        tick();
        checks++; if (ex_mem_read !== 1'b1 || ex_mem_to_reg !== 2'd1 || ex_pc_plus4 !== 32'h200) begin errors++; $display("FAIL b2b_first: mr=%0b mtr=%0d pc=%h expected 1/1/200", ex_mem_read, ex_mem_to_reg, ex_pc_plus4); end
        checks++; if (alu_sign !== 1'b1 || alu_ctrl !== 5'd9 || ex_rs_addr !== 5'd3) begin errors++; $display("FAIL b2b_first_alu: sign=%0b ctrl=%0d rs=%0d expected 1/9/3", alu_sign, alu_ctrl, ex_rs_addr); end
        id_rs_addr = 0; id_rt_addr = 0; id_dst = 31; id_mem_read = 0; id_mem_to_reg = 2'd2;
        id_pc_plus4 = 32'h204; id_sign = 0; id_alu_ctrl = 5'd0;
        tick();
        checks++; if (ex_mem_read !== 1'b0 || ex_mem_to_reg !== 2'd2 || ex_pc_plus4 !== 32'h204 || ex_dst !== 5'd31) begin errors++; $display("FAIL b2b_second: mr=%0b mtr=%0d pc=%h dst=%0d expected 0/2/204/31", ex_mem_read, ex_mem_to_reg, ex_pc_plus4, ex_dst); end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_zero_reg();
        test_shifts();
        test_stall_flush();
        test_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
